bpred_bimodal_btb: RTL and testbench

Parametrised next-generation fetch-stage branch predictor: a tagged branch target buffer (BTB) plus a bimodal table of saturating counters. Both tables are indexed by the fetch PC. It returns a registered taken/target prediction one cycle after lookup and trains from a resolved-branch update port. It replaces the fixed 8-bit-indexed, untagged, oracle-taken predictor. New capabilities: tag match, counter-based direction, and a reset-time table initialisation sweep.

---
 rtl/bpred_pkg.sv | 30 +++
 rtl/bpred_sdp_ram.sv | 24 ++
 rtl/bpred_bimodal_btb.sv | 186 ++++++++++++++++++
 tb/tb_bpred_bimodal_btb.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
// Shared encodings, state enum and helpers for the bimodal/BTB branch predictor.
package bpred_pkg;

  localparam int DEF_PC_W  = 32;
  localparam int DEF_TAG_W = 14;
  localparam int DEF_CTR_W = 2;

  localparam logic [DEF_CTR_W-1:0] CTR_WNT = DEF_CTR_W'((1 << (DEF_CTR_W - 1)) - 1);
  localparam logic [DEF_CTR_W-1:0] CTR_MAX = DEF_CTR_W'((1 << DEF_CTR_W) - 1);

  localparam int PC_INC = 4;

  // BTB entry at the default geometry; the top builds the same layout from its parameters.
  typedef struct packed {
    logic                  valid;
    logic [DEF_TAG_W-1:0]  tag;
    logic [DEF_PC_W-3:0]   target;
  } btb_entry_t;

  typedef enum logic {INIT, RUN} state_e;

  function automatic int ctr_wnt(int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int ctr_max(int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/bpred_sdp_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port, read-before-write.
module bpred_sdp_ram #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bpred_bimodal_btb.sv
// Fetch-stage predictor: tagged BTB plus bimodal saturating counters, with reset-time table sweep.
module bpred_bimodal_btb
  import bpred_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int BTB_IDX_W = 8,
  parameter int TAG_W     = 14,
  parameter int BHT_IDX_W = 9,
  parameter int CTR_W     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lu_valid,
  input  logic [PC_W-1:0] lu_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  output logic            btb_hit,
  input  logic            up_valid,
  input  logic [PC_W-1:0] up_pc,
  input  logic            up_taken,
  input  logic [PC_W-1:0] up_target,
  output logic            init_busy
);

  localparam int IDX_W = (BTB_IDX_W > BHT_IDX_W) ? BTB_IDX_W : BHT_IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_wnt(CTR_W));
  localparam logic [CTR_W-1:0] CTR_TOP  = CTR_W'(ctr_max(CTR_W));

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [PC_W-3:0]   target;
  } entry_t;
  localparam int ENT_W = $bits(entry_t);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             run;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == '1) state_d = RUN;
      end
      default: ;
    endcase
  end

  assign run       = (state_q == RUN);
  assign init_busy = !run;

  logic [BTB_IDX_W-1:0] lu_btb_idx, up_btb_idx;
  logic [BHT_IDX_W-1:0] lu_bht_idx, up_bht_idx;
  logic [TAG_W-1:0]     lu_tag, up_tag;

  assign lu_btb_idx = lu_pc[BTB_IDX_W+1:2];
  assign up_btb_idx = up_pc[BTB_IDX_W+1:2];
  assign lu_bht_idx = lu_pc[BHT_IDX_W+1:2];
  assign up_bht_idx = up_pc[BHT_IDX_W+1:2];
  assign lu_tag     = lu_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
  assign up_tag     = up_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];

  logic unused_bits;
  assign unused_bits = ^{up_pc[1:0], up_pc[PC_W-1:BTB_IDX_W+TAG_W+2], up_target[1:0]};

  logic                 btb_we;
  logic [BTB_IDX_W-1:0] btb_waddr;
  entry_t               btb_wdata, btb_rdata;

  always_comb begin
    btb_we    = 1'b0;
    btb_waddr = up_btb_idx;
    btb_wdata = '{valid: 1'b1, tag: up_tag, target: up_target[PC_W-1:2]};
    if (!run) begin
      btb_we    = 1'b1;
      btb_waddr = sweep_q[BTB_IDX_W-1:0];
      btb_wdata = '0;
    end else if (up_valid && up_taken) begin
      btb_we = 1'b1;
    end
  end

  bpred_sdp_ram #(.DW(ENT_W), .AW(BTB_IDX_W)) u_btb (
    .clk(clk), .we_i(btb_we), .waddr_i(btb_waddr), .wdata_i(btb_wdata),
    .raddr_i(lu_btb_idx), .rdata_o(btb_rdata)
  );

  // Counter table is replicated so lookup and update each own a read port.
  logic                 bht_we;
  logic [BHT_IDX_W-1:0] bht_waddr;
  logic [CTR_W-1:0]     bht_wdata, lk_ctr_rd, up_ctr_rd;

  logic                 up1_v_q, up1_taken_q;
  logic [BHT_IDX_W-1:0] up1_idx_q;
  logic                 wr_v_q;
  logic [BHT_IDX_W-1:0] wr_idx_q;
  logic [CTR_W-1:0]     wr_ctr_q;
  logic [CTR_W-1:0]     ctr_base, ctr_new;

  assign ctr_base = (wr_v_q && wr_idx_q == up1_idx_q) ? wr_ctr_q : up_ctr_rd;

  always_comb begin
    ctr_new = ctr_base;
    if (up1_taken_q) begin
      if (ctr_base != CTR_TOP) ctr_new = ctr_base + CTR_W'(1);
    end else begin
      if (ctr_base != '0) ctr_new = ctr_base - CTR_W'(1);
    end
  end

  always_comb begin
    bht_we    = run && up1_v_q;
    bht_waddr = up1_idx_q;
    bht_wdata = ctr_new;
    if (!run) begin
      bht_we    = 1'b1;
      bht_waddr = sweep_q[BHT_IDX_W-1:0];
      bht_wdata = CTR_INIT;
    end
  end

  bpred_sdp_ram #(.DW(CTR_W), .AW(BHT_IDX_W)) u_bht_lk (
    .clk(clk), .we_i(bht_we), .waddr_i(bht_waddr), .wdata_i(bht_wdata),
    .raddr_i(lu_bht_idx), .rdata_o(lk_ctr_rd)
  );

  bpred_sdp_ram #(.DW(CTR_W), .AW(BHT_IDX_W)) u_bht_up (
    .clk(clk), .we_i(bht_we), .waddr_i(bht_waddr), .wdata_i(bht_wdata),
    .raddr_i(up_bht_idx), .rdata_o(up_ctr_rd)
  );

  logic                 lu_v_q;
  logic [TAG_W-1:0]     lu_tag_q;
  logic [BHT_IDX_W-1:0] lu_idx_q;
  logic [PC_W-1:0]      lu_pc4_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      up1_v_q <= 1'b0;
      wr_v_q  <= 1'b0;
      lu_v_q  <= 1'b0;
    end else begin
      up1_v_q <= run && up_valid;
      wr_v_q  <= run && up1_v_q;
      lu_v_q  <= run && lu_valid;
    end
  end

  always_ff @(posedge clk) begin
    up1_taken_q <= up_taken;
    up1_idx_q   <= up_bht_idx;
    wr_idx_q    <= up1_idx_q;
    wr_ctr_q    <= ctr_new;
    lu_tag_q    <= lu_tag;
    lu_idx_q    <= lu_bht_idx;
    lu_pc4_q    <= lu_pc + PC_W'(PC_INC);
  end

  // The counter read for a lookup misses a write landing on the same edge; forward it.
  logic [CTR_W-1:0] lk_ctr;
  logic             hit, taken;

  assign lk_ctr = (wr_v_q && wr_idx_q == lu_idx_q) ? wr_ctr_q : lk_ctr_rd;
  assign hit    = lu_v_q && btb_rdata.valid && (btb_rdata.tag == lu_tag_q);
  assign taken  = hit && lk_ctr[CTR_W-1];

  assign pred_valid  = lu_v_q;
  assign btb_hit     = hit;
  assign pred_taken  = taken;
  assign pred_target = !lu_v_q ? '0 : (taken ? {btb_rdata.target, 2'b00} : lu_pc4_q);

endmodule

// File: tb/tb_bpred_bimodal_btb.sv
// Directed bench for bpred_bimodal_btb at default geometry.
module tb_bpred_bimodal_btb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lu_valid = 1'b0;
  logic [31:0] lu_pc = '0;
  logic        pred_valid, pred_taken, btb_hit, init_busy;
  logic [31:0] pred_target;
  logic        up_valid = 1'b0;
  logic [31:0] up_pc = '0;
  logic        up_taken = 1'b0;
  logic [31:0] up_target = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bpred_bimodal_btb dut (
    .clk(clk), .rst_n(rst_n),
    .lu_valid(lu_valid), .lu_pc(lu_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_target(pred_target), .btb_hit(btb_hit),
    .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken), .up_target(up_target),
    .init_busy(init_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pred(input string tag, input logic v, input logic hit,
                          input logic tk, input logic [31:0] tgt);
    chk({tag, ".valid"},  {31'd0, pred_valid}, {31'd0, v});
    chk({tag, ".hit"},    {31'd0, btb_hit},    {31'd0, hit});
    chk({tag, ".taken"},  {31'd0, pred_taken}, {31'd0, tk});
    chk({tag, ".target"}, pred_target,         tgt);
  endtask

  task automatic lookup(input logic [31:0] pc);
    lu_valid = 1'b1;
    lu_pc    = pc;
    tick();
    lu_valid = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    up_valid  = 1'b1;
    up_pc     = pc;
    up_taken  = tk;
    up_target = tgt;
    tick();
    up_valid  = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (init_busy && n < 2000) begin
      n++;
      tick();
    end
    chk(tag, n, 512);
  endtask

  initial begin
    // reset, then a second reset part-way through the sweep
    tick();
    chk_pred("reset", 1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset.busy", {31'd0, init_busy}, 32'd1);
    rst_n = 1'b1;
    repeat (100) tick();
    chk("midsweep.busy", {31'd0, init_busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("midreset.busy", {31'd0, init_busy}, 32'd1);
    chk_pred("midreset", 1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    wait_init("init.cycles");

    // first lookup accepted as soon as init_busy drops
    lookup(32'h1234_5670);
    chk_pred("cold", 1'b1, 1'b0, 1'b0, 32'h1234_5674);
    tick();
    chk("idle.valid", {31'd0, pred_valid}, 32'd0);

    // two back-to-back taken updates: WNT(1) -> 2 -> 3
    update(32'h100, 1'b1, 32'h400);
    update(32'h100, 1'b1, 32'h400);
    lookup(32'h100);
    chk_pred("trained", 1'b1, 1'b1, 1'b1, 32'h400);

    update(32'h100, 1'b0, 32'h0);
    lookup(32'h100);
    chk_pred("nt1", 1'b1, 1'b1, 1'b1, 32'h400);
    update(32'h100, 1'b0, 32'h0);
    lookup(32'h100);
    chk_pred("nt2", 1'b1, 1'b1, 1'b0, 32'h104);

    // alias: same BTB index, different tag, different counter
    update(32'h100, 1'b1, 32'h400);
    lookup(32'h500);
    chk_pred("alias", 1'b1, 1'b0, 1'b0, 32'h504);
    lookup(32'h100);
    chk_pred("alias.orig", 1'b1, 1'b1, 1'b1, 32'h400);

    // same-cycle update and lookup: read-before-write
    up_valid = 1'b1; up_pc = 32'h100; up_taken = 1'b1; up_target = 32'h800;
    lu_valid = 1'b1; lu_pc = 32'h100;
    tick();
    up_valid = 1'b0; lu_valid = 1'b0;
    chk_pred("rbw.old", 1'b1, 1'b1, 1'b1, 32'h400);
    lookup(32'h100);
    chk_pred("rbw.new", 1'b1, 1'b1, 1'b1, 32'h800);

    // saturate at max, then a not-taken update must leave the BTB alone
    update(32'h100, 1'b1, 32'h800);
    update(32'h100, 1'b0, 32'hAAA0);
    lookup(32'h100);
    chk_pred("sat.max", 1'b1, 1'b1, 1'b1, 32'h800);

    // clamp at zero: 1 -> 0 -> 0 -> 1 (not taken) -> 2 (taken)
    update(32'h200, 1'b0, 32'h0);
    update(32'h200, 1'b0, 32'h0);
    lookup(32'h200);
    chk_pred("sat.zero.miss", 1'b1, 1'b0, 1'b0, 32'h204);
    update(32'h200, 1'b1, 32'h900);
    lookup(32'h200);
    chk_pred("sat.zero.1", 1'b1, 1'b1, 1'b0, 32'h204);
    update(32'h200, 1'b1, 32'h900);
    lookup(32'h200);
    chk_pred("sat.zero.2", 1'b1, 1'b1, 1'b1, 32'h900);

    // reset after training clears outputs and tables
    lu_valid = 1'b1; lu_pc = 32'h100;
    rst_n = 1'b0;
    tick();
    lu_valid = 1'b0;
    chk_pred("retrain.reset", 1'b0, 1'b0, 1'b0, 32'h0);
    chk("retrain.busy", {31'd0, init_busy}, 32'd1);
    rst_n = 1'b1;
    wait_init("reinit.cycles");
    lookup(32'h100);
    chk_pred("reinit.miss", 1'b1, 1'b0, 1'b0, 32'h104);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
